// File: rtl/instr_sequencer.sv
// Instruction sequencer: an 8-entry instruction store that is replayed to a
// valid/ready consumer, one word every two cycles, for a requested count.
// Optional feature: define INSTR_SEQ_LOOP_EN to add a 'loop' input that
// restarts the run from entry 0 instead of finishing.
module instr_sequencer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        start,
  input  logic [3:0]  count,
`ifdef INSTR_SEQ_LOOP_EN
  input  logic        loop,
`endif
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [31:0] issue_instr,
  output logic [2:0]  issue_addr,
  output logic [3:0]  issue_op,
  output logic [3:0]  issue_ra,
  output logic [3:0]  issue_rb,
  output logic [1:0]  issue_tag,
  output logic        busy,
  output logic        done,
  output logic        wr_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  pc_q, pc_d;
  logic [3:0]  remaining_q, remaining_d;
  logic [31:0] issueInstr_q, issueInstr_d;
  logic [2:0]  issueAddr_q, issueAddr_d;
  logic        wrErr_q, wrErr_d;
  logic [3:0]  countClamped;
  logic [31:0] store_q [DEPTH];
`ifdef INSTR_SEQ_LOOP_EN
  logic [3:0]  countLatched_q, countLatched_d;
`endif

  assign countClamped = (count > 4'd8) ? 4'd8 : count;

  // Store is written only while idle and is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == IDLE)) begin
      store_q[wr_addr] <= wr_data;
    end
  end

  // Control and issue registers; reset aborts any run immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      pc_q           <= 3'd0;
      remaining_q    <= 4'd0;
      issueInstr_q   <= 32'd0;
      issueAddr_q    <= 3'd0;
      wrErr_q        <= 1'b0;
`ifdef INSTR_SEQ_LOOP_EN
      countLatched_q <= 4'd0;
`endif
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      remaining_q    <= remaining_d;
      issueInstr_q   <= issueInstr_d;
      issueAddr_q    <= issueAddr_d;
      wrErr_q        <= wrErr_d;
`ifdef INSTR_SEQ_LOOP_EN
      countLatched_q <= countLatched_d;
`endif
    end
  end

  // Next-state logic: start in IDLE, read the store in FETCH, hold the word in ISSUE until accepted.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    remaining_d    = remaining_q;
    issueInstr_d   = issueInstr_q;
    issueAddr_d    = issueAddr_q;
    wrErr_d        = wr_en && (state_q != IDLE);
`ifdef INSTR_SEQ_LOOP_EN
    countLatched_d = countLatched_q;
`endif
    issue_valid    = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          pc_d        = 3'd0;
          remaining_d = countClamped;
`ifdef INSTR_SEQ_LOOP_EN
          countLatched_d = countClamped;
`endif
          state_d     = (countClamped == 4'd0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        issueInstr_d = store_q[pc_q];
        issueAddr_d  = pc_q;
        state_d      = ISSUE;
      end
      ISSUE: begin
        issue_valid = 1'b1;
        if (issue_ready) begin
          pc_d        = pc_q + 3'd1;
          remaining_d = remaining_q - 4'd1;
          if (remaining_q > 4'd1) begin
            state_d = FETCH;
          end else begin
            state_d = DONE;
`ifdef INSTR_SEQ_LOOP_EN
            if (loop) begin
              pc_d        = 3'd0;
              remaining_d = countLatched_q;
              state_d     = FETCH;
            end
`endif
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign issue_instr = issueInstr_q;
  assign issue_addr  = issueAddr_q;
  assign issue_op    = issueInstr_q[3:0];
  assign issue_ra    = issueInstr_q[7:4];
  assign issue_rb    = issueInstr_q[11:8];
  assign issue_tag   = issueInstr_q[13:12];
  assign wr_err      = wrErr_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer.
module tb_instr_sequencer;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic        start;
  logic [3:0]  count;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_instr;
  logic [2:0]  issue_addr;
  logic [3:0]  issue_op;
  logic [3:0]  issue_ra;
  logic [3:0]  issue_rb;
  logic [1:0]  issue_tag;
  logic        busy;
  logic        done;
  logic        wr_err;
`ifdef INSTR_SEQ_LOOP_EN
  logic        loop;
`endif

  int checkCount = 0;
  int passCount  = 0;
  logic [31:0] expWord [8];

  instr_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .count       (count),
`ifdef INSTR_SEQ_LOOP_EN
    .loop        (loop),
`endif
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_instr (issue_instr),
    .issue_addr  (issue_addr),
    .issue_op    (issue_op),
    .issue_ra    (issue_ra),
    .issue_rb    (issue_rb),
    .issue_tag   (issue_tag),
    .busy        (busy),
    .done        (done),
    .wr_err      (wr_err)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      passCount++;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  // Run with the consumer state as set by the caller until done, checking every issued word.
  task automatic drainRun(input string tag, input int expIssues);
    int  n = 0;
    bit  seenDone = 1'b0;
    for (int cyc = 0; cyc < 60 && !seenDone; cyc++) begin
      if (issue_valid && issue_ready) begin
        checkOutput({tag, "_instr"}, issue_instr, expWord[n % 8]);
        checkOutput({tag, "_addr"}, 32'(issue_addr), 32'(n % 8));
        n++;
      end
      if (done) seenDone = 1'b1;
      else tick();
    end
    checkOutput({tag, "_doneSeen"}, 32'(seenDone), 32'd1);
    checkOutput({tag, "_issues"}, 32'(n), 32'(expIssues));
    tick();
    checkOutput({tag, "_idleBusy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_idleDone"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [31:0] heldInstr;
    reset       = 1'b1;
    wr_en       = 1'b0;
    wr_addr     = 3'd0;
    wr_data     = 32'd0;
    start       = 1'b0;
    count       = 4'd0;
    issue_ready = 1'b0;
`ifdef INSTR_SEQ_LOOP_EN
    loop        = 1'b0;
`endif
    expWord[0] = 32'h0000_0543;
    expWord[1] = 32'h0000_1543;
    expWord[2] = 32'h0000_2543;
    for (int i = 3; i < 8; i++) begin
      expWord[i] = 32'hA500_0543 | (32'(i) << 16) | (32'(i % 4) << 12);
    end

    tick();
    tick();
    checkOutput("rst_valid", 32'(issue_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_wrErr", 32'(wr_err), 32'd0);
    checkOutput("rst_instr", issue_instr, 32'd0);
    checkOutput("rst_addr", 32'(issue_addr), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) applyStimulus(3'(i), expWord[i]);
    checkOutput("wr_idleNoErr", 32'(wr_err), 32'd0);

    // Three issues back to back with the consumer always ready.
    issue_ready = 1'b1;
    start = 1'b1;
    count = 4'd3;
    tick();
    start = 1'b0;
    count = 4'd0;
    checkOutput("a_fetchValid", 32'(issue_valid), 32'd0);
    checkOutput("a_fetchBusy", 32'(busy), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("a_valid", 32'(issue_valid), 32'd1);
      checkOutput("a_instr", issue_instr, expWord[k]);
      checkOutput("a_addr", 32'(issue_addr), 32'(k));
      checkOutput("a_op", 32'(issue_op), 32'd3);
      checkOutput("a_ra", 32'(issue_ra), 32'd4);
      checkOutput("a_rb", 32'(issue_rb), 32'd5);
      checkOutput("a_tag", 32'(issue_tag), 32'(k));
      tick();
      checkOutput("a_gapValid", 32'(issue_valid), 32'd0);
    end
    checkOutput("a_done", 32'(done), 32'd1);
    checkOutput("a_doneBusy", 32'(busy), 32'd1);
    tick();
    checkOutput("a_idleDone", 32'(done), 32'd0);
    checkOutput("a_idleBusy", 32'(busy), 32'd0);

    // Consumer stalls for five cycles; the word must hold steady.
    issue_ready = 1'b0;
    start = 1'b1;
    count = 4'd1;
    tick();
    start = 1'b0;
    tick();
    heldInstr = issue_instr;
    checkOutput("b_instr", issue_instr, expWord[0]);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("b_holdValid", 32'(issue_valid), 32'd1);
      checkOutput("b_holdInstr", issue_instr, heldInstr);
    end
    issue_ready = 1'b1;
    tick();
    checkOutput("b_done", 32'(done), 32'd1);
    checkOutput("b_oneIssue", 32'(issue_valid), 32'd0);
    tick();

    // Zero count goes straight to DONE.
    start = 1'b1;
    count = 4'd0;
    tick();
    start = 1'b0;
    checkOutput("c_valid", 32'(issue_valid), 32'd0);
    checkOutput("c_busy", 32'(busy), 32'd1);
    checkOutput("c_done", 32'(done), 32'd1);
    tick();
    checkOutput("c_idleBusy", 32'(busy), 32'd0);
    checkOutput("c_idleDone", 32'(done), 32'd0);

    // Count above eight is clamped to a full pass over the store.
    start = 1'b1;
    count = 4'd15;
    tick();
    start = 1'b0;
    drainRun("d", 8);

    // Write and second start while busy are both dropped.
    issue_ready = 1'b0;
    start = 1'b1;
    count = 4'd2;
    tick();
    start   = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 3'd1;
    wr_data = 32'hDEAD_BEEF;
    tick();
    wr_en = 1'b0;
    checkOutput("e_wrErr", 32'(wr_err), 32'd1);
    start = 1'b1;
    count = 4'd5;
    tick();
    start = 1'b0;
    checkOutput("e_wrErrPulse", 32'(wr_err), 32'd0);
    issue_ready = 1'b1;
    drainRun("e", 2);

    // Write and start in the same idle cycle: the new word is issued.
    expWord[0] = 32'h0000_3543;
    wr_en   = 1'b1;
    wr_addr = 3'd0;
    wr_data = expWord[0];
    start   = 1'b1;
    count   = 4'd1;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    checkOutput("f_wrErr", 32'(wr_err), 32'd0);
    drainRun("f", 1);

    // Reset in the middle of ISSUE clears outputs at once and gives no done.
    issue_ready = 1'b0;
    start = 1'b1;
    count = 4'd3;
    tick();
    start = 1'b0;
    tick();
    checkOutput("g_preValid", 32'(issue_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("g_valid", 32'(issue_valid), 32'd0);
    checkOutput("g_busy", 32'(busy), 32'd0);
    checkOutput("g_instr", issue_instr, 32'd0);
    checkOutput("g_addr", 32'(issue_addr), 32'd0);
    tick();
    reset = 1'b0;
    issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("g_quietValid", 32'(issue_valid), 32'd0);
      checkOutput("g_quietDone", 32'(done), 32'd0);
    end
    start = 1'b1;
    count = 4'd3;
    tick();
    start = 1'b0;
    drainRun("g", 3);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
